quick_spi_arbiter: RTL and testbench
====================================

Name: quick_spi_arbiter

Overview:
Round-robin arbiter and sequencer that shares one quick_spi master between NUMBER_OF_REQUESTERS clients. It accepts one request at a time and launches a single SPI transaction with the winner's slave index, operation and payload. It holds those fields stable until end_of_transaction, then returns the read word and a done pulse to the owning requester. The block sits directly between the client logic and the quick_spi instance.

Parameters:
NUMBER_OF_REQUESTERS, 4, number of clients (>=2)
NUMBER_OF_SLAVES, 2, must match the SPI master; slave index width
INCOMING_DATA_WIDTH, 8, must match the SPI master
OUTGOING_DATA_WIDTH, 16, must match the SPI master
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
req_valid  in  NUMBER_OF_REQUESTERS  per-client request; held until req_ready
req_slave  in  NUMBER_OF_REQUESTERS*NUMBER_OF_SLAVES  flattened slave indices; client i at slice i
req_operation  in  NUMBER_OF_REQUESTERS  per-client op; 0=READ, 1=WRITE
req_outgoing_data  in  NUMBER_OF_REQUESTERS*OUTGOING_DATA_WIDTH  flattened payloads
req_ready  out  NUMBER_OF_REQUESTERS  one-cycle accept pulse, one-hot
rsp_valid  out  NUMBER_OF_REQUESTERS  one-cycle completion pulse, one-hot
rsp_data  out  INCOMING_DATA_WIDTH  read word; valid only while rsp_valid is nonzero
rsp_error  out  1  qualifies rsp_valid; 1 = request rejected or timed out
busy  out  1  high in every state except IDLE
spi_enable  out  1  to the master's enable input
spi_start_transaction  out  1  to the master's start_transaction input
spi_slave  out  NUMBER_OF_SLAVES  to the master's slave input (an index)
spi_operation  out  1  to the master's operation input
spi_outgoing_data  out  OUTGOING_DATA_WIDTH  to the master's outgoing_data input
spi_end_of_transaction  in  1  from the master
spi_incoming_data  in  INCOMING_DATA_WIDTH  from the master
spi_reset_n  out  1  to the master's synchronous reset_n input

Behaviour:
- Reset values:
  - req_ready, rsp_valid, rsp_data, rsp_error, busy, spi_start_transaction, spi_slave, spi_operation and spi_outgoing_data are all 0.
  - spi_enable=1 and spi_reset_n=1.
  - The round-robin pointer resets to NUMBER_OF_REQUESTERS-1, so requester 0 wins first after reset.
- Reset mid-operation: an assertion in any state returns the block to IDLE immediately. An in-flight response is lost and no rsp_valid is issued.
- States are IDLE, LAUNCH, BUSY and DONE. All outputs are registered.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching upward from pointer+1 (modulo N).
  - Latch the winner index, slave, operation and payload into the spi_* registers, update the pointer to the winner, and go to LAUNCH.
  - A winner with req_slave >= NUMBER_OF_SLAVES instead goes to LAUNCH with a reject flag set.
- LAUNCH, one cycle:
  - req_ready[winner]=1.
  - spi_start_transaction=1, unless the reject flag is set.
  - Next state is BUSY, or DONE if rejected.
- BUSY:
  - spi_slave, spi_operation and spi_outgoing_data stay stable; the master samples them throughout ACTIVE.
  - On the cycle spi_end_of_transaction=1, capture spi_incoming_data; it is valid only in that cycle. Then go to DONE.
- DONE, one cycle:
  - rsp_valid[owner]=1 and rsp_data = the captured word.
  - rsp_error=1 with rsp_data=0 if rejected.
  - Next state is IDLE.
- Launch spacing: after eot, spi_start_transaction asserts no earlier than 3 cycles after the eot cycle (DONE, then IDLE, then LAUNCH). This guarantees the master has left its WAIT state.
- Minimum back-to-back overhead is 3 cycles between eot and the next start.
- Fairness: under continuous demand from all clients, grants rotate 0,1,...,N-1,0.
- A requester keeping req_valid high after req_ready is treated as a new request.
- Clients other than the winner see no pulses.

Optional Feature:
Macro QUICK_SPI_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY. If it reaches TIMEOUT_CYCLES with no eot, the block drives spi_reset_n=0 for exactly one cycle to abort the master.
  - It then enters DONE with rsp_error=1 and rsp_data=0.
  - The counter clears on entry to BUSY.
- Not defined: the counter is absent, spi_reset_n is constantly 1, and BUSY waits indefinitely.

Test Plan:
- Single read: after reset, client 2 requests slave 1, READ; master model returns 0xA5 -> req_ready=0100, one start pulse with spi_slave=1, then rsp_valid=0100 with rsp_data=0xA5 and rsp_error=0.
- Round-robin: all four clients hold req_valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with exactly one start per grant.
- Stability and spacing: a write with payload 0x1234 -> spi_outgoing_data=0x1234 constant from LAUNCH through eot, and the next start exactly 3 cycles after eot.
- Invalid slave: client 1 requests slave index 3 with NUMBER_OF_SLAVES=2 -> req_ready=0010, no start pulse, rsp_valid=0010 with rsp_error=1 and rsp_data=0.
- Reset mid-BUSY: assert reset_n=0 between start and eot -> all outputs return to reset values asynchronously, no rsp_valid, and the next grant goes to client 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): model never raises eot -> spi_reset_n low for 1 cycle after 16 BUSY cycles, then rsp_error=1 to the owner.

Source files
------------

// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one quick_spi master between several clients.
// Optional watchdog abort of a hung master is enabled by defining QUICK_SPI_ARBITER_TIMEOUT_EN.
module quick_spi_arbiter #(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int NUMBER_OF_SLAVES     = 2,
  parameter int INCOMING_DATA_WIDTH  = 8,
  parameter int OUTGOING_DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                  req_valid,
  input  logic [NUMBER_OF_REQUESTERS*NUMBER_OF_SLAVES-1:0] req_slave,
  input  logic [NUMBER_OF_REQUESTERS-1:0]                  req_operation,
  input  logic [NUMBER_OF_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_outgoing_data,
  output logic [NUMBER_OF_REQUESTERS-1:0]                  req_ready,
  output logic [NUMBER_OF_REQUESTERS-1:0]                  rsp_valid,
  output logic [INCOMING_DATA_WIDTH-1:0]                   rsp_data,
  output logic                                             rsp_error,
  output logic                                             busy,
  output logic                                             spi_enable,
  output logic                                             spi_start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]                      spi_slave,
  output logic                                             spi_operation,
  output logic [OUTGOING_DATA_WIDTH-1:0]                   spi_outgoing_data,
  input  logic                                             spi_end_of_transaction,
  input  logic [INCOMING_DATA_WIDTH-1:0]                   spi_incoming_data,
  output logic                                             spi_reset_n
);

  localparam int N  = NUMBER_OF_REQUESTERS;
  localparam int SW = NUMBER_OF_SLAVES;
  localparam int IW = INCOMING_DATA_WIDTH;
  localparam int OW = OUTGOING_DATA_WIDTH;
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [PW-1:0]   owner, owner_d;
  logic            reject, reject_d;
  logic [N-1:0]    req_ready_d, rsp_valid_d;
  logic [IW-1:0]   rsp_data_d;
  logic            rsp_error_d, busy_d, start_d;
  logic [SW-1:0]   slave_d;
  logic            op_d;
  logic [OW-1:0]   out_d;

  logic            found;
  logic [PW-1:0]   winner, cand;
  logic [SW-1:0]   sel_slave;
  logic            sel_op, sel_reject;
  logic [OW-1:0]   sel_data;

  assign spi_enable = 1'b1;

  // Search upward from the client after the last winner so every client gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    sel_slave  = req_slave[int'(winner)*SW +: SW];
    sel_op     = req_operation[winner];
    sel_data   = req_outgoing_data[int'(winner)*OW +: OW];
    sel_reject = (sel_slave >= SW'(NUMBER_OF_SLAVES));
  end

`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcount, tcount_d;
  logic          abort, abort_d;
  logic          spi_reset_n_d;

  // The abort cycle keeps the master in synchronous reset for exactly one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcount      <= '0;
      abort       <= 1'b0;
      spi_reset_n <= 1'b1;
    end else begin
      tcount      <= tcount_d;
      abort       <= abort_d;
      spi_reset_n <= spi_reset_n_d;
    end
  end
`else
  assign spi_reset_n = 1'b1;
`endif

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    owner_d     = owner;
    reject_d    = reject;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_error_d = 1'b0;
    start_d     = 1'b0;
    slave_d     = spi_slave;
    op_d        = spi_operation;
    out_d       = spi_outgoing_data;
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
    tcount_d      = tcount;
    abort_d       = 1'b0;
    spi_reset_n_d = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          ptr_d              = winner;
          owner_d            = winner;
          reject_d           = sel_reject;
          slave_d            = sel_slave;
          op_d               = sel_op;
          out_d              = sel_data;
          req_ready_d[winner] = 1'b1;
          start_d            = !sel_reject;
          state_d            = LAUNCH;
        end
      end
      LAUNCH: begin
        if (reject) begin
          rsp_valid_d[owner] = 1'b1;
          rsp_error_d        = 1'b1;
          state_d            = DONE;
        end else begin
          state_d = BUSY;
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
          tcount_d = '0;
`endif
        end
      end
      BUSY: begin
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
        if (abort) begin
          rsp_valid_d[owner] = 1'b1;
          rsp_error_d        = 1'b1;
          state_d            = DONE;
        end else if (spi_end_of_transaction) begin
          rsp_valid_d[owner] = 1'b1;
          rsp_data_d         = spi_incoming_data;
          state_d            = DONE;
        end else begin
          tcount_d = tcount + CW'(1);
          if (tcount == CW'(TIMEOUT_CYCLES - 1)) begin
            abort_d       = 1'b1;
            spi_reset_n_d = 1'b0;
          end
        end
`else
        if (spi_end_of_transaction) begin
          rsp_valid_d[owner] = 1'b1;
          rsp_data_d         = spi_incoming_data;
          state_d            = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Outputs are registered alongside the state so they line up with it exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      ptr                   <= PW'(N - 1);
      owner                 <= '0;
      reject                <= 1'b0;
      req_ready             <= '0;
      rsp_valid             <= '0;
      rsp_data              <= '0;
      rsp_error             <= 1'b0;
      busy                  <= 1'b0;
      spi_start_transaction <= 1'b0;
      spi_slave             <= '0;
      spi_operation         <= 1'b0;
      spi_outgoing_data     <= '0;
    end else begin
      state                 <= state_d;
      ptr                   <= ptr_d;
      owner                 <= owner_d;
      reject                <= reject_d;
      req_ready             <= req_ready_d;
      rsp_valid             <= rsp_valid_d;
      rsp_data              <= rsp_data_d;
      rsp_error             <= rsp_error_d;
      busy                  <= busy_d;
      spi_start_transaction <= start_d;
      spi_slave             <= slave_d;
      spi_operation         <= op_d;
      spi_outgoing_data     <= out_d;
    end
  end

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Self-checking bench for quick_spi_arbiter with a behavioural quick_spi master model.
// Define QUICK_SPI_ARBITER_TIMEOUT_EN to also exercise the watchdog.
module tb_quick_spi_arbiter;
  localparam int N  = 4;
  localparam int NS = 2;
  localparam int IW = 8;
  localparam int OW = 16;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N*NS-1:0]   req_slave;
  logic [N-1:0]      req_operation;
  logic [N*OW-1:0]   req_outgoing_data;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [IW-1:0]     rsp_data;
  logic              rsp_error, busy, spi_enable, spi_start_transaction;
  logic [NS-1:0]     spi_slave;
  logic              spi_operation;
  logic [OW-1:0]     spi_outgoing_data;
  logic              spi_end_of_transaction;
  logic [IW-1:0]     spi_incoming_data;
  logic              spi_reset_n;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int start_count = 0;
  int eot_cycle = -1;
  bit master_hang = 1'b0;
  bit master_fixed = 1'b0;
  logic [IW-1:0] master_word = '0;
  logic [IW-1:0] word_q[$];

  quick_spi_arbiter #(
    .NUMBER_OF_REQUESTERS(N), .NUMBER_OF_SLAVES(NS),
    .INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_slave(req_slave), .req_operation(req_operation),
    .req_outgoing_data(req_outgoing_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy), .spi_enable(spi_enable),
    .spi_start_transaction(spi_start_transaction), .spi_slave(spi_slave),
    .spi_operation(spi_operation), .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data),
    .spi_reset_n(spi_reset_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Master model: after a start it answers with one eot pulse 1..5 cycles later.
  initial begin : master_model
    bit pending;
    int cnt;
    logic [IW-1:0] pend;
    pending = 1'b0; cnt = 0; pend = '0;
    spi_end_of_transaction = 1'b0;
    spi_incoming_data = '0;
    forever begin
      @(negedge clk);
      spi_end_of_transaction = 1'b0;
      spi_incoming_data = IW'($urandom);
      if (!reset_n || !spi_reset_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (cnt <= 1) begin
            spi_end_of_transaction = 1'b1;
            spi_incoming_data = pend;
            pending = 1'b0;
            eot_cycle = cycle;
            word_q.push_back(pend);
          end else begin
            cnt--;
          end
        end
        if (spi_start_transaction) begin
          start_count++;
          if (!master_hang) begin
            pending = 1'b1;
            cnt = $urandom_range(1, 5);
            pend = master_fixed ? master_word : IW'($urandom);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    word_q.delete();
  endtask

  task automatic wait_ready(input int limit, output logic [N-1:0] rdy, output logic st,
                            output logic [NS-1:0] sl, output logic op,
                            output logic [OW-1:0] od, output bit ok);
    ok = 1'b0; rdy = '0; st = 1'b0; sl = '0; op = 1'b0; od = '0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (req_ready != '0) begin
        rdy = req_ready; st = spi_start_transaction; sl = spi_slave;
        op = spi_operation; od = spi_outgoing_data; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int limit, output logic [N-1:0] rv, output logic [IW-1:0] rd,
                          output logic re, output bit ok);
    ok = 1'b0; rv = '0; rd = '0; re = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (rsp_valid != '0) begin
        rv = rsp_valid; rd = rsp_data; re = rsp_error; ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [IW-1:0] pop_word();
    if (word_q.size() == 0) return 'x;
    return word_q.pop_front();
  endfunction

  function automatic int rr_next(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic randomize_client(input int i);
    req_slave[i*NS +: NS] = NS'($urandom_range(0, NS - 1));
    req_operation[i] = 1'($urandom_range(0, 1));
    req_outgoing_data[i*OW +: OW] = OW'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '0; req_slave = '0; req_operation = '0; req_outgoing_data = '0;
    tick();
    tick();
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_error, busy, spi_start_transaction, spi_operation} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl got rdy=%b rv=%b err=%b busy=%b st=%b op=%b required all 0",
               req_ready, rsp_valid, rsp_error, busy, spi_start_transaction, spi_operation);
    end
    n_cmp++;
    if ({rsp_data, spi_slave, spi_outgoing_data} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_data got rd=%h sl=%h od=%h required 0", rsp_data, spi_slave, spi_outgoing_data);
    end
    n_cmp++;
    if ({spi_enable, spi_reset_n} !== 2'b11) begin
      n_err++;
      $display("[TB] FAIL reset_spi got en=%b rstn=%b required 1 1", spi_enable, spi_reset_n);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [N-1:0] rdy, rv; logic st, op, re; logic [NS-1:0] sl; logic [OW-1:0] od;
    logic [IW-1:0] rd; bit ok; int s0;
    s0 = start_count;
    master_fixed = 1'b1; master_word = 8'hA5;
    req_slave[2*NS +: NS] = 2'd1; req_operation[2] = 1'b0; req_outgoing_data[2*OW +: OW] = 16'h0F0F;
    req_valid = 4'b0100;
    wait_ready(10, rdy, st, sl, op, od, ok);
    req_valid = '0;
    n_cmp++;
    if (!ok || rdy !== 4'b0100 || st !== 1'b1 || sl !== 2'd1) begin
      n_err++;
      $display("[TB] FAIL single_launch got ok=%0d rdy=%b st=%b sl=%0d required 1 0100 1 1", ok, rdy, st, sl);
    end
    wait_rsp(20, rv, rd, re, ok);
    void'(pop_word());
    n_cmp++;
    if (!ok || rv !== 4'b0100 || rd !== 8'hA5 || re !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL single_rsp got ok=%0d rv=%b rd=%h err=%b required 1 0100 a5 0", ok, rv, rd, re);
    end
    n_cmp++;
    if (start_count - s0 !== 1) begin
      n_err++;
      $display("[TB] FAIL single_starts got %0d required 1", start_count - s0);
    end
    master_fixed = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rdy, rv; logic st, op, re; logic [NS-1:0] sl; logic [OW-1:0] od;
    logic [IW-1:0] rd, exp_w; bit ok; int s0, last, g;
    logic [NS-1:0] exp_sl; logic exp_op; logic [OW-1:0] exp_od;
    apply_reset();
    for (int i = 0; i < N; i++) randomize_client(i);
    last = N - 1;
    s0 = start_count;
    req_valid = '1;
    for (int t = 0; t < 8; t++) begin
      g = rr_next(last, req_valid);
      exp_sl = req_slave[g*NS +: NS]; exp_op = req_operation[g]; exp_od = req_outgoing_data[g*OW +: OW];
      wait_ready(10, rdy, st, sl, op, od, ok);
      randomize_client(g);
      n_cmp++;
      if (!ok || rdy !== N'(1 << g)) begin
        n_err++;
        $display("[TB] FAIL rr_grant t=%0d got ok=%0d rdy=%b required grant %0d", t, ok, rdy, g);
      end
      n_cmp++;
      if (st !== 1'b1 || sl !== exp_sl || op !== exp_op || od !== exp_od) begin
        n_err++;
        $display("[TB] FAIL rr_fields t=%0d got st=%b sl=%0d op=%b od=%h required 1 %0d %b %h",
                 t, st, sl, op, od, exp_sl, exp_op, exp_od);
      end
      wait_rsp(20, rv, rd, re, ok);
      exp_w = pop_word();
      if (t == 7) req_valid = '0;
      n_cmp++;
      if (!ok || rv !== N'(1 << g) || rd !== exp_w || re !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL rr_rsp t=%0d got ok=%0d rv=%b rd=%h err=%b required %0d %h 0",
                 t, ok, rv, rd, re, g, exp_w);
      end
      last = g;
    end
    n_cmp++;
    if (start_count - s0 !== 8) begin
      n_err++;
      $display("[TB] FAIL rr_starts got %0d required 8", start_count - s0);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] rdy, rv; logic st, op, re; logic [NS-1:0] sl; logic [OW-1:0] od;
    logic [IW-1:0] rd, exp_w; bit ok, got, bad; int lc;
    req_slave[3*NS +: NS] = 2'd0; req_operation[3] = 1'b1; req_outgoing_data[3*OW +: OW] = 16'h1234;
    req_valid = 4'b1000;
    wait_ready(10, rdy, st, sl, op, od, ok);
    req_outgoing_data[3*OW +: OW] = 16'hBEEF;
    bad = (!ok || od !== 16'h1234);
    got = 1'b0; rd = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid != '0) begin got = 1'b1; rd = rsp_data; break; end
      if (spi_outgoing_data !== 16'h1234 || spi_slave !== 2'd0 || spi_operation !== 1'b1) bad = 1'b1;
    end
    exp_w = pop_word();
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("[TB] FAIL b2b_stable got od=%h sl=%0d op=%b required 1234 0 1 throughout", spi_outgoing_data, spi_slave, spi_operation);
    end
    n_cmp++;
    if (!got || rd !== exp_w) begin
      n_err++;
      $display("[TB] FAIL b2b_rsp1 got ok=%0d rd=%h required %h", got, rd, exp_w);
    end
    wait_ready(10, rdy, st, sl, op, od, ok);
    lc = cycle;
    req_valid = '0;
    n_cmp++;
    if (!ok || lc - eot_cycle !== 3 || od !== 16'hBEEF || st !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL b2b_spacing got ok=%0d gap=%0d od=%h st=%b required gap 3 beef 1", ok, lc - eot_cycle, od, st);
    end
    wait_rsp(20, rv, rd, re, ok);
    exp_w = pop_word();
    n_cmp++;
    if (!ok || rv !== 4'b1000 || rd !== exp_w) begin
      n_err++;
      $display("[TB] FAIL b2b_rsp2 got ok=%0d rv=%b rd=%h required 1000 %h", ok, rv, rd, exp_w);
    end
  endtask

  task automatic test_invalid_slave();
    logic [N-1:0] rdy, rv; logic st, op, re; logic [NS-1:0] sl; logic [OW-1:0] od;
    logic [IW-1:0] rd; bit ok; int s0;
    s0 = start_count;
    req_slave[1*NS +: NS] = 2'd3; req_operation[1] = 1'b0; req_outgoing_data[1*OW +: OW] = 16'h5555;
    req_valid = 4'b0010;
    wait_ready(10, rdy, st, sl, op, od, ok);
    req_valid = '0;
    n_cmp++;
    if (!ok || rdy !== 4'b0010 || st !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL inv_launch got ok=%0d rdy=%b st=%b required 0010 0", ok, rdy, st);
    end
    wait_rsp(10, rv, rd, re, ok);
    n_cmp++;
    if (!ok || rv !== 4'b0010 || re !== 1'b1 || rd !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL inv_rsp got ok=%0d rv=%b err=%b rd=%h required 0010 1 00", ok, rv, re, rd);
    end
    n_cmp++;
    if (start_count - s0 !== 0) begin
      n_err++;
      $display("[TB] FAIL inv_starts got %0d required 0", start_count - s0);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [N-1:0] rdy, rv; logic st, op, re; logic [NS-1:0] sl; logic [OW-1:0] od;
    logic [IW-1:0] rd, exp_w; bit ok, seen;
    master_hang = 1'b1;
    req_slave[2*NS +: NS] = 2'd1; req_operation[2] = 1'b1; req_outgoing_data[2*OW +: OW] = 16'hA1B2;
    req_valid = 4'b0100;
    wait_ready(10, rdy, st, sl, op, od, ok);
    req_valid = '0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, spi_operation, spi_start_transaction, req_ready, rsp_valid} !== '0 ||
        spi_slave !== '0 || spi_outgoing_data !== '0) begin
      n_err++;
      $display("[TB] FAIL midrst_async got busy=%b op=%b sl=%0d od=%h required all 0",
               busy, spi_operation, spi_slave, spi_outgoing_data);
    end
    tick();
    tick();
    reset_n = 1'b1;
    word_q.delete();
    master_hang = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid != '0 || busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("[TB] FAIL midrst_quiet got a response or busy after reset required none");
    end
    req_slave[0*NS +: NS] = 2'd0; req_slave[3*NS +: NS] = 2'd1;
    req_valid = 4'b1001;
    wait_ready(10, rdy, st, sl, op, od, ok);
    req_valid = 4'b1000;
    n_cmp++;
    if (!ok || rdy !== 4'b0001) begin
      n_err++;
      $display("[TB] FAIL midrst_grant got ok=%0d rdy=%b required 0001", ok, rdy);
    end
    wait_rsp(20, rv, rd, re, ok);
    exp_w = pop_word();
    n_cmp++;
    if (!ok || rv !== 4'b0001 || rd !== exp_w) begin
      n_err++;
      $display("[TB] FAIL midrst_rsp got ok=%0d rv=%b rd=%h required 0001 %h", ok, rv, rd, exp_w);
    end
    wait_ready(10, rdy, st, sl, op, od, ok);
    req_valid = '0;
    n_cmp++;
    if (!ok || rdy !== 4'b1000) begin
      n_err++;
      $display("[TB] FAIL midrst_grant2 got ok=%0d rdy=%b required 1000", ok, rdy);
    end
    wait_rsp(20, rv, rd, re, ok);
    void'(pop_word());
  endtask

`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    logic [N-1:0] rdy, rv; logic st, op, re; logic [NS-1:0] sl; logic [OW-1:0] od;
    logic [IW-1:0] rd; bit ok; int lc, first_low, low_cnt, rsp_cyc;
    master_hang = 1'b1;
    req_slave[3*NS +: NS] = 2'd0; req_operation[3] = 1'b0;
    req_valid = 4'b1000;
    wait_ready(10, rdy, st, sl, op, od, ok);
    lc = cycle;
    req_valid = '0;
    first_low = -1; low_cnt = 0; rsp_cyc = -1; rv = '0; rd = '0; re = 1'b0;
    for (int i = 0; i < 3 * TO; i++) begin
      tick();
      if (spi_reset_n === 1'b0) begin
        if (first_low < 0) first_low = cycle;
        low_cnt++;
      end
      if (rsp_valid != '0) begin
        rsp_cyc = cycle; rv = rsp_valid; rd = rsp_data; re = rsp_error;
        break;
      end
    end
    n_cmp++;
    if (first_low - lc !== TO + 1 || low_cnt !== 1) begin
      n_err++;
      $display("[TB] FAIL timeout_abort got offset=%0d width=%0d required %0d 1", first_low - lc, low_cnt, TO + 1);
    end
    n_cmp++;
    if (rsp_cyc - lc !== TO + 2 || rv !== 4'b1000 || re !== 1'b1 || rd !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL timeout_rsp got offset=%0d rv=%b err=%b rd=%h required %0d 1000 1 00",
               rsp_cyc - lc, rv, re, rd, TO + 2);
    end
    master_hang = 1'b0;
  endtask
`endif

  initial begin
    $display("[TB] starting quick_spi_arbiter bench");
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_invalid_slave();
    test_reset_mid_busy();
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
